muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of register_file.
- SrcA/SrcB come from RD1/RD2; Result and rd_out go back to WD3/A3 for writeback.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.
- Start/busy/done handshake; the control unit stalls the PC while busy is high.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 5, iteration counter width; XLEN must equal 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request, sampled on a clk edge when state is IDLE or DONE.
- funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  XLEN  operand rs1 (from RD1); dividend / multiplicand.
- SrcB  input  XLEN  operand rs2 (from RD2); divisor / multiplier.
- rd_in  input  5  destination register, captured with start.
- busy  output  1  high while computing (CALC or FIXUP).
- done  output  1  one-cycle pulse; Result and rd_out are valid.
- Result  output  XLEN  result of the last completed operation; held until the next accepted start.
- rd_out  output  5  rd_in captured with the accepted start; drives A3.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0, done=0, Result=0, rd_out=0; counter and internal registers cleared.
  - Reset asserted mid-operation aborts it; no done is produced.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: busy=0, done=0. When start=1 on an edge:
  - latch funct3, rd_in, |SrcA| and |SrcB| (signed ops only), and the result sign; counter=0.
  - go to CALC.
- CALC: busy=1. Each edge does one iteration and counter+1. After the edge with counter=XLEN-1, go to FIXUP.
  - Multiply: 64-bit product register, shift-add on LSB of multiplier.
  - Divide: restoring; {rem,quot} shifted left, subtract the divisor when non-negative.
- FIXUP: busy=1, one edge.
  - Apply two's-complement sign correction.
    - MULH: negate if signs differ.
    - MULHSU: SrcA sign only.
    - DIV quotient: sign = signA XOR signB.
    - REM: sign of the dividend.
  - Select the low word (MUL) or high word (MULH*); load Result. Go to DONE.
- DONE: done=1, busy=0 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: done is high in the cycle after edge N+XLEN+1, where edge N samples start. Default: 34 edges.
- start while busy=1 is ignored; operands, funct3 and rd_in changes during busy have no effect.
- Division by zero (no trap):
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU = SrcA.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF:
  - quotient = 0x80000000, REM = 0.
  - The general algorithm must produce this; no special path is required without the optional feature.
- All arithmetic is modulo 2^XLEN; the negation of 0x80000000 is itself.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in IDLE/DONE, when start=1 and any of the cases below holds, the unit loads Result directly and goes to DONE. done is then high the cycle after the sampling edge, and busy never asserts.
  - Divide-by-zero.
  - Signed overflow.
  - Multiply with either operand zero (Result = 0).
- Undefined: every operation takes the full XLEN+2-edge latency, with identical Result values.

Test Plan:
- MUL, SrcA=7, SrcB=6, rd_in=5 -> busy for 33 cycles; done pulse; Result=0x0000002A, rd_out=5; done low the next cycle.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> Result=0xFFFFFFFE. MULH, same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- Signed divide, -20 (0xFFFFFFEC) by 3:
  - DIV -> 0xFFFFFFFA.
  - REM -> 0xFFFFFFFE.
  - Then DIVU 100/7 -> 14 and REMU -> 2, issued back-to-back with start held high in the DONE cycle.
- DIVU 0x1234/0 -> Result 0xFFFFFFFF. REMU 0x1234/0 -> Result 0x1234. DIV 0x80000000 by 0xFFFFFFFF -> Result 0x80000000, REM -> 0. Latency: 34 edges, or 1 edge with MULDIV_EARLY_OUT_EN.
- Start MUL 3x3, toggle start and change SrcA at cycle 10 -> ignored; done at 34 edges with Result=9.
- Start DIV, assert reset at cycle 15 for one edge -> busy=0, done=0, Result=0, rd_out=0; no done pulse afterwards. A new start then completes normally.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the register-file read ports and the RV32M
// multiply/divide unit. The unit side takes the slave modport.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Result;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, SrcA, SrcB, rd_in,
        input  busy, done, Result, rd_out
    );

    modport slave (
        input  start, funct3, SrcA, SrcB, rd_in,
        output busy, done, Result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: finish trivial cases (div by zero, overflow, zero multiply) in one edge.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic   clk,
    input  logic   reset,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] prod_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    logic              sgn_a, sgn_b;
    logic [XLEN-1:0]   abs_a_d, abs_b_d;
    logic              neg_d;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_tmp;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] prod_d;
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   div_word;
    logic [XLEN-1:0]   result_d;
`ifdef MULDIV_EARLY_OUT_EN
    logic              early_d;
    logic [XLEN-1:0]   early_res_d;
`endif

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Result = result_q;
    assign bus.rd_out = rd_out_q;

    // Operand conditioning at start: magnitudes for signed operands, result sign.
    always_comb begin
        sgn_a   = 1'b0;
        sgn_b   = 1'b0;
        neg_d   = 1'b0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin
                sgn_a = bus.SrcA[XLEN-1];
                sgn_b = bus.SrcB[XLEN-1];
            end
            3'b010: sgn_a = bus.SrcA[XLEN-1];
            default: ;
        endcase
        abs_a_d = sgn_a ? -bus.SrcA : bus.SrcA;
        abs_b_d = sgn_b ? -bus.SrcB : bus.SrcB;
        case (bus.funct3)
            3'b001:  neg_d = sgn_a ^ sgn_b;
            3'b010:  neg_d = sgn_a;
            // A zero divisor must leave the all-ones quotient unnegated.
            3'b100:  neg_d = (sgn_a ^ sgn_b) && (bus.SrcB != '0);
            3'b110:  neg_d = sgn_a;
            default: neg_d = 1'b0;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        early_d     = 1'b0;
        early_res_d = '0;
        if (bus.funct3[2]) begin
            if (bus.SrcB == '0) begin
                early_d     = 1'b1;
                early_res_d = bus.funct3[1] ? bus.SrcA : '1;
            end else if (!bus.funct3[0] && bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}
                         && bus.SrcB == '1) begin
                early_d     = 1'b1;
                early_res_d = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
        end else if (bus.SrcA == '0 || bus.SrcB == '0) begin
            early_d     = 1'b1;
            early_res_d = '0;
        end
    end
`endif

    // One iteration. Multiply: prod = {acc, multiplier}; divide: prod = {rem, quot}.
    always_comb begin
        mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
        div_tmp = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_ge  = div_tmp >= {1'b0, b_q};
        div_rem = div_ge ? (div_tmp[XLEN-1:0] - b_q) : div_tmp[XLEN-1:0];
        if (op_q[2]) begin
            prod_d = {div_rem, prod_q[XLEN-2:0], div_ge};
        end else begin
            prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_neg = neg_q ? -prod_q : prod_q;
        div_word = op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
        if (op_q[2]) begin
            result_d = neg_q ? -div_word : div_word;
        end else if (op_q[1:0] == 2'b00) begin
            result_d = prod_neg[XLEN-1:0];
        end else begin
            result_d = prod_neg[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (bus.start) begin
                        op_q     <= bus.funct3;
                        rd_out_q <= bus.rd_in;
                        a_q      <= abs_a_d;
                        b_q      <= abs_b_d;
                        neg_q    <= neg_d;
                        cnt_q    <= '0;
                        prod_q   <= bus.funct3[2] ? {{XLEN{1'b0}}, abs_a_d}
                                                  : {{XLEN{1'b0}}, abs_b_d};
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_d) begin
                            result_q <= early_res_d;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
`endif
                    end
                end
                S_CALC: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    result_q <= result_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a monitor checks each done pulse.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t sb[$];

    muldiv_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (!f[2] && (a == 0 || b == 0)) return 1;
`endif
        return 34;
    endfunction

    // Called at a negedge while the unit is idle or in its done cycle.
    task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit track);
        exp_t e;
        bus.funct3 = f;
        bus.SrcA   = a;
        bus.SrcB   = b;
        bus.rd_in  = rd;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (track) begin
            e.res  = ref_model(f, a, b);
            e.rd   = rd;
            e.lat  = exp_lat(f, a, b);
            e.t0   = cyc;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 100);
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles, expected done", name, n);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 with Result=%h, expected no done", bus.Result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, 64'(bus.Result), 64'(e.res));
                chk({e.name, "_rd"}, 64'(bus.rd_out), 64'(e.rd));
                chk({e.name, "_latency"}, 64'(cyc - e.t0 + 1), 64'(e.lat));
                if (bus.busy) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_busy_at_done: got busy=1, expected 0", e.name);
                end
            end
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, bc;
        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.SrcA   = '0;
        bus.SrcB   = '0;
        bus.rd_in  = '0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result", 64'(bus.Result), 64'd0);
        chk("rst_rd", 64'(bus.rd_out), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // MUL 7x6 with busy-length and single-cycle done checks.
        issue("mul_7x6", 3'd0, 32'd7, 32'd6, 5'd5, 1'b1);
        n = 0;
        bc = 0;
        do begin
            @(negedge clk);
            if (bus.busy) bc++;
            n++;
        end while (!bus.done && n < 100);
        chk("mul_busy_cycles", 64'(bc), 64'd33);
        @(negedge clk);
        chk("mul_done_one_cycle", 64'(bus.done), 64'd0);

        issue("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1); wait_done("mulhu_ff");
        @(negedge clk);
        issue("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1); wait_done("mulh_ff");
        @(negedge clk);
        issue("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b1); wait_done("mulhsu");
        @(negedge clk);
        issue("div_m20_3", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd4, 1'b1); wait_done("div_m20_3");
        @(negedge clk);
        issue("rem_m20_3", 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6, 1'b1); wait_done("rem_m20_3");
        // Back-to-back: start held high in the done cycle.
        issue("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd7, 1'b1); wait_done("divu_100_7");
        issue("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd8, 1'b1); wait_done("remu_100_7");
        @(negedge clk);
        issue("divu_by0", 3'd5, 32'h1234, 32'd0, 5'd9, 1'b1); wait_done("divu_by0");
        @(negedge clk);
        issue("remu_by0", 3'd7, 32'h1234, 32'd0, 5'd10, 1'b1); wait_done("remu_by0");
        @(negedge clk);
        issue("div_by0_neg", 3'd4, 32'hFFFF_FFF0, 32'd0, 5'd11, 1'b1); wait_done("div_by0_neg");
        @(negedge clk);
        issue("rem_by0_neg", 3'd6, 32'hFFFF_FFF0, 32'd0, 5'd12, 1'b1); wait_done("rem_by0_neg");
        @(negedge clk);
        issue("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1); wait_done("div_ovf");
        @(negedge clk);
        issue("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1); wait_done("rem_ovf");
        @(negedge clk);

        // Inputs changing while busy must be ignored.
        issue("mul_3x3_ignore", 3'd0, 32'd3, 32'd3, 5'd15, 1'b1);
        repeat (9) @(negedge clk);
        bus.start  = 1'b1;
        bus.SrcA   = 32'd99;
        bus.funct3 = 3'd5;
        bus.rd_in  = 5'd30;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_done("mul_3x3_ignore");
        @(negedge clk);

        // Reset mid-divide aborts without a done pulse.
        issue("div_abort", 3'd4, 32'd1000, 32'd7, 5'd9, 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_result", 64'(bus.Result), 64'd0);
        chk("abort_rd", 64'(bus.rd_out), 64'd0);
        repeat (40) @(negedge clk);
        issue("after_abort", 3'd4, 32'd1000, 32'd7, 5'd17, 1'b1); wait_done("after_abort");
        @(negedge clk);

        // Randomized mix, sometimes back-to-back.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            issue("rand", f, a, b, 5'($urandom_range(0, 31)), 1'b1);
            wait_done("rand");
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                chk("rand_done_low", 64'(bus.done), 64'd0);
            end
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
